// File: rtl/hwpe_ctrl_pkg.sv
// Shared HWPE control definitions: register map offsets, acquire response codes and offloader FSM states.
// Used by hwpe_ctrl_offloader (optional feature macro: HWPE_CTRL_OFFLOADER_POLL_EN).
package hwpe_ctrl_pkg;

   localparam logic [31:0] TRIGGER_OFFS   = 32'h0000_0000;
   localparam logic [31:0] ACQUIRE_OFFS   = 32'h0000_0004;
   localparam logic [31:0] FINISHED_OFFS  = 32'h0000_0008;
   localparam logic [31:0] STATUS_OFFS    = 32'h0000_000C;
   localparam logic [31:0] RUNNING_OFFS   = 32'h0000_0010;
   localparam logic [31:0] SOFTCLEAR_OFFS = 32'h0000_0014;
   localparam logic [31:0] IO_BASE_OFFS   = 32'h0000_0040;

   // Negative acquire responses: every context busy (-1), another PE is offloading (-2)
   localparam logic [31:0] ACQ_ALL_BUSY   = 32'hFFFF_FFFF;
   localparam logic [31:0] ACQ_OTHER_PE   = 32'hFFFF_FFFE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACQ,
      S_ACQ_RSP,
      S_BACKOFF,
      S_WR,
      S_TRIG,
      S_WAIT
   } offl_state_e;

   // Any negative acquire response means the job could not be placed yet
   function automatic logic acq_refused(input logic [31:0] rsp);
      return rsp[31];
   endfunction

endpackage

// File: rtl/hwpe_ctrl_offloader.sv
// Offloads a job to an HWPE over a periph initiator port: acquire, parameter writes, trigger, completion.
// Macro HWPE_CTRL_OFFLOADER_POLL_EN: completion by polling STATUS instead of the evt_i pulse.
module hwpe_ctrl_offloader
   import hwpe_ctrl_pkg::*;
#(
   parameter int unsigned N_IO_REGS   = 2,
   parameter int unsigned ID_WIDTH    = 16,
   parameter int unsigned RETRY_DELAY = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   input  logic                          job_valid_i,
   output logic                          job_ready_o,
   input  logic [N_IO_REGS-1:0][31:0]    job_params_i,
   output logic                          done_valid_o,
   output logic [7:0]                    done_job_id_o,
   output logic                          busy_o,
   output logic                          req_o,
   input  logic                          gnt_i,
   output logic [31:0]                   add_o,
   output logic                          wen_o,
   output logic [3:0]                    be_o,
   output logic [31:0]                   data_o,
   output logic [ID_WIDTH-1:0]           id_o,
   input  logic                          r_valid_i,
   input  logic [31:0]                   r_data_i,
   input  logic                          evt_i
);

   localparam int unsigned KW = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;
   localparam int unsigned RW = $clog2(RETRY_DELAY + 1);

   offl_state_e                 r_state;
   offl_state_e                 w_state_next;
   logic [N_IO_REGS-1:0][31:0]  r_params;
   logic [KW-1:0]               r_word_idx;
   logic [RW-1:0]               r_retry_cnt;
   logic                        r_outstanding;
   logic [7:0]                  r_job_id;
   logic                        r_done_valid;
   logic [7:0]                  r_done_id;
   logic                        w_issue;
   logic                        w_rsp;
   logic                        w_refused;
   logic                        w_last_word;
   logic                        w_done;
   logic                        w_unused;

`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
   localparam logic [3:0] POLL_LAST = 4'd15;
   logic [3:0]                  r_poll_cnt;
   assign w_unused = evt_i;
`else
   assign w_unused = ^r_data_i[30:8];
`endif

   assign w_issue     = req_o & gnt_i;
   assign w_rsp       = r_valid_i & r_outstanding;
   assign w_refused   = acq_refused(r_data_i);
   assign w_last_word = (r_word_idx == KW'(N_IO_REGS - 1));

   assign busy_o        = (r_state != S_IDLE);
   assign be_o          = 4'hF;
   assign id_o          = '0;
   assign done_valid_o  = r_done_valid;
   assign done_job_id_o = r_done_id;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else if (clear_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Bus fields are decoded from state alone, so they hold steady while a request waits for gnt_i
   always_comb begin
      w_state_next = r_state;
      job_ready_o  = 1'b0;
      req_o        = 1'b0;
      add_o        = '0;
      wen_o        = 1'b1;
      data_o       = '0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            job_ready_o = 1'b1;
            if (job_valid_i) w_state_next = S_ACQ;
         end
         S_ACQ: begin
            req_o = 1'b1;
            add_o = ACQUIRE_OFFS;
            if (gnt_i) w_state_next = S_ACQ_RSP;
         end
         S_ACQ_RSP: begin
            if (w_rsp) w_state_next = w_refused ? S_BACKOFF : S_WR;
         end
         S_BACKOFF: begin
            if (r_retry_cnt == RW'(RETRY_DELAY - 1)) w_state_next = S_ACQ;
         end
         S_WR: begin
            if (!r_outstanding) begin
               req_o  = 1'b1;
               add_o  = IO_BASE_OFFS + (32'(r_word_idx) << 2);
               wen_o  = 1'b0;
               data_o = r_params[r_word_idx];
            end else if (w_rsp && w_last_word) begin
               w_state_next = S_TRIG;
            end
         end
         S_TRIG: begin
            if (!r_outstanding) begin
               req_o = 1'b1;
               add_o = TRIGGER_OFFS;
               wen_o = 1'b0;
            end else if (w_rsp) begin
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
            if (!r_outstanding) begin
               if (r_poll_cnt == POLL_LAST) begin
                  req_o = 1'b1;
                  add_o = STATUS_OFFS;
               end
            end else if (w_rsp && (r_data_i == '0)) begin
               w_done       = 1'b1;
               w_state_next = S_IDLE;
            end
`else
            if (evt_i) begin
               w_done       = 1'b1;
               w_state_next = S_IDLE;
            end
`endif
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath: captured parameters, transaction tracking, retry counter and completion reporting
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_params      <= '0;
         r_word_idx    <= '0;
         r_retry_cnt   <= '0;
         r_outstanding <= 1'b0;
         r_job_id      <= '0;
         r_done_valid  <= 1'b0;
         r_done_id     <= '0;
      end else if (clear_i) begin
         r_params      <= '0;
         r_word_idx    <= '0;
         r_retry_cnt   <= '0;
         r_outstanding <= 1'b0;
         r_job_id      <= '0;
         r_done_valid  <= 1'b0;
         r_done_id     <= '0;
      end else begin
         if ((r_state == S_IDLE) && job_valid_i) r_params <= job_params_i;

         if (w_issue) begin
            r_outstanding <= 1'b1;
         end else if (w_rsp) begin
            r_outstanding <= 1'b0;
         end

         if ((r_state == S_BACKOFF) && (w_state_next == S_BACKOFF)) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
         end else begin
            r_retry_cnt <= '0;
         end

         if ((r_state == S_ACQ_RSP) && w_rsp && !w_refused) begin
            r_job_id   <= r_data_i[7:0];
            r_word_idx <= '0;
         end else if ((r_state == S_WR) && w_rsp && !w_last_word) begin
            r_word_idx <= r_word_idx + 1'b1;
         end

         r_done_valid <= w_done;
         if (w_done) r_done_id <= r_job_id;
      end
   end

`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
   // Poll timer runs only while idle in WAIT and restarts after every STATUS read
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_poll_cnt <= '0;
      end else if (clear_i) begin
         r_poll_cnt <= '0;
      end else if ((r_state != S_WAIT) || w_issue || w_rsp) begin
         r_poll_cnt <= '0;
      end else if (!r_outstanding && (r_poll_cnt != POLL_LAST)) begin
         r_poll_cnt <= r_poll_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hwpe_ctrl_offloader.sv
// Randomized bench for hwpe_ctrl_offloader: a periph responder plus a transaction-list model of each job.
// Targets the default build (HWPE_CTRL_OFFLOADER_POLL_EN undefined).
module tb_hwpe_ctrl_offloader;

   localparam int N_IO_REGS   = 2;
   localparam int ID_WIDTH    = 16;
   localparam int RETRY_DELAY = 8;

   logic                       clk_i = 1'b0;
   logic                       rst_ni;
   logic                       clear_i;
   logic                       job_valid_i;
   logic                       job_ready_o;
   logic [N_IO_REGS-1:0][31:0] job_params_i;
   logic                       done_valid_o;
   logic [7:0]                 done_job_id_o;
   logic                       busy_o;
   logic                       req_o;
   logic                       gnt_i;
   logic [31:0]                add_o;
   logic                       wen_o;
   logic [3:0]                 be_o;
   logic [31:0]                data_o;
   logic [ID_WIDTH-1:0]        id_o;
   logic                       r_valid_i;
   logic [31:0]                r_data_i;
   logic                       evt_i;

   hwpe_ctrl_offloader #(
      .N_IO_REGS  (N_IO_REGS),
      .ID_WIDTH   (ID_WIDTH),
      .RETRY_DELAY(RETRY_DELAY)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .job_valid_i  (job_valid_i),
      .job_ready_o  (job_ready_o),
      .job_params_i (job_params_i),
      .done_valid_o (done_valid_o),
      .done_job_id_o(done_job_id_o),
      .busy_o       (busy_o),
      .req_o        (req_o),
      .gnt_i        (gnt_i),
      .add_o        (add_o),
      .wen_o        (wen_o),
      .be_o         (be_o),
      .data_o       (data_o),
      .id_o         (id_o),
      .r_valid_i    (r_valid_i),
      .r_data_i     (r_data_i),
      .evt_i        (evt_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] data;
   } txn_t;

   txn_t        expQ[$];
   logic [31:0] acqPlan[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          maxGntDelay = 0;
   bit          fixedGnt = 1'b0;
   int          evtReqs = 0;
   int          evtDone = 0;
   int          doneCount = 0;
   int          expectedDones = 0;
   logic [7:0]  lastDoneId = '0;
   int          txnCount = 0;
   bit          outstanding = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Periph responder and bus monitor: grants with random latency, answers one cycle or more later
   initial begin
      int          gntWait = -1;
      int          rspWait = 0;
      logic [31:0] rspData = '0;
      bit          rspRefused = 1'b0;
      bit          prevReq = 1'b0;
      bit          prevGnt = 1'b0;
      logic [31:0] prevAdd = '0;
      logic [31:0] prevData = '0;
      logic        prevWen = 1'b1;
      bit          gapActive = 1'b0;
      int          gapCnt = 0;
      txn_t        e;
      gnt_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; evt_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (done_valid_o) begin
            doneCount++;
            lastDoneId = done_job_id_o;
         end
         if (gapActive) begin
            if (req_o) begin
               checkOutput("backoff_idle_cycles", gapCnt, RETRY_DELAY);
               gapActive = 1'b0;
            end else begin
               gapCnt++;
            end
         end
         if (req_o) checkOutput("single_outstanding", 32'(outstanding), 0);
         r_valid_i = 1'b0;
         r_data_i  = $urandom();
         if (outstanding) begin
            if (rspWait == 0) begin
               r_valid_i   = 1'b1;
               r_data_i    = rspData;
               outstanding = 1'b0;
               if (rspRefused) begin
                  gapActive = 1'b1;
                  gapCnt    = 0;
               end
            end else begin
               rspWait--;
            end
         end else if (!req_o && $urandom_range(0, 7) == 0) begin
            r_valid_i = 1'b1;
         end
         gnt_i = 1'b0;
         if (req_o) begin
            if (prevReq && !prevGnt) begin
               checkOutput("stable_add", add_o, prevAdd);
               checkOutput("stable_data", data_o, prevData);
               checkOutput("stable_wen", 32'(wen_o), 32'(prevWen));
            end
            if (gntWait < 0) gntWait = fixedGnt ? maxGntDelay : int'($urandom_range(0, maxGntDelay));
            if (gntWait == 0) begin
               gnt_i   = 1'b1;
               gntWait = -1;
               txnCount++;
               checkOutput("txn_expected", 32'(expQ.size() != 0), 1);
               if (expQ.size() != 0) begin
                  e = expQ.pop_front();
                  checkOutput("add", add_o, e.addr);
                  checkOutput("wen", 32'(wen_o), 32'(e.wen));
                  if (!e.wen) checkOutput("wdata", data_o, e.data);
               end
               checkOutput("be", 32'(be_o), 32'hF);
               checkOutput("id", 32'(id_o), 0);
               checkOutput("busy_during_txn", 32'(busy_o), 1);
               outstanding = 1'b1;
               rspWait     = $urandom_range(0, 2);
               rspRefused  = 1'b0;
               if (wen_o && add_o == 32'h4 && acqPlan.size() != 0) begin
                  rspData    = acqPlan.pop_front();
                  rspRefused = $signed(rspData) < 0;
               end else begin
                  rspData = $urandom();
               end
            end else begin
               gntWait--;
            end
         end
         prevReq  = req_o;
         prevGnt  = gnt_i;
         prevAdd  = add_o;
         prevData = data_o;
         prevWen  = wen_o;
         evt_i = 1'b0;
         if (evtDone < evtReqs) begin
            evt_i = 1'b1;
            evtDone++;
         end else if (expQ.size() != 0 && $urandom_range(0, 15) == 0) begin
            evt_i = 1'b1;
         end
      end
   end

   // Model of one job: each refused acquire is retried, then every parameter word, then the trigger
   task automatic applyStimulus(input logic [31:0] p0, input logic [31:0] p1, input int nRefuse,
                                input bit allBusy, input logic [7:0] jobId);
      logic [31:0] code;
      evtReqs++;
      for (int r = 0; r < nRefuse; r++) begin
         code = (allBusy || $urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
         acqPlan.push_back(code);
         expQ.push_back('{32'h04, 1'b1, 32'h0});
      end
      acqPlan.push_back({1'b0, 23'($urandom()), jobId});
      expQ.push_back('{32'h04, 1'b1, 32'h0});
      expQ.push_back('{32'h40, 1'b0, p0});
      expQ.push_back('{32'h44, 1'b0, p1});
      expQ.push_back('{32'h00, 1'b0, 32'h0});
      repeat (3) @(negedge clk_i);
      checkOutput("no_done_from_idle_evt", doneCount, expectedDones);
      checkOutput("job_ready_idle", 32'(job_ready_o), 1);
      job_valid_i  = 1'b1;
      job_params_i = {p1, p0};
      @(negedge clk_i);
      job_valid_i  = 1'b0;
      job_params_i = {32'($urandom()), 32'($urandom())};
   endtask

   task automatic waitJob(input logic [7:0] jobId);
      int cyc = 0;
      while ((expQ.size() != 0 || outstanding) && cyc < 3000) begin
         @(negedge clk_i);
         cyc++;
      end
      checkOutput("job_bus_phase_timeout", 32'(cyc < 3000), 1);
      repeat ($urandom_range(1, 4)) @(negedge clk_i);
      checkOutput("busy_in_wait", 32'(busy_o), 1);
      checkOutput("no_early_done", doneCount, expectedDones);
      evtReqs++;
      cyc = 0;
      while (doneCount == expectedDones && cyc < 10) begin
         @(negedge clk_i);
         cyc++;
      end
      expectedDones++;
      checkOutput("done_count", doneCount, expectedDones);
      checkOutput("done_id", 32'(lastDoneId), 32'(jobId));
      repeat (3) @(negedge clk_i);
      checkOutput("done_single_pulse", doneCount, expectedDones);
      checkOutput("idle_after_done", 32'(busy_o), 0);
   endtask

   initial begin
      int          base;
      int          cyc;
      logic [7:0]  jid;
      int          nr;
      rst_ni = 1'b0; clear_i = 1'b0; job_valid_i = 1'b0; job_params_i = '0;
      repeat (3) @(negedge clk_i);
      checkOutput("rst_req", 32'(req_o), 0);
      checkOutput("rst_wen", 32'(wen_o), 1);
      checkOutput("rst_add", add_o, 0);
      checkOutput("rst_data", data_o, 0);
      checkOutput("rst_done_valid", 32'(done_valid_o), 0);
      checkOutput("rst_done_id", 32'(done_job_id_o), 0);
      checkOutput("rst_busy", 32'(busy_o), 0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      checkOutput("ready_after_rst", 32'(job_ready_o), 1);

      maxGntDelay = 0; fixedGnt = 1'b1;
      applyStimulus(32'hA, 32'hB, 0, 1'b0, 8'h03);
      waitJob(8'h03);

      maxGntDelay = 2; fixedGnt = 1'b0;
      applyStimulus($urandom(), $urandom(), 2, 1'b1, 8'h05);
      waitJob(8'h05);

      maxGntDelay = 3; fixedGnt = 1'b1;
      applyStimulus($urandom(), $urandom(), 1, 1'b0, 8'h77);
      waitJob(8'h77);

      maxGntDelay = 0; fixedGnt = 1'b0;
      applyStimulus($urandom(), $urandom(), 0, 1'b0, 8'hFF);
      waitJob(8'hFF);

      for (int j = 0; j < 8; j++) begin
         maxGntDelay = $urandom_range(0, 3);
         jid = 8'($urandom());
         applyStimulus($urandom(), $urandom(), $urandom_range(0, 2), 1'b0, jid);
         waitJob(jid);
      end

      maxGntDelay = 1; fixedGnt = 1'b0;
      nr   = $urandom_range(0, 1);
      base = txnCount;
      applyStimulus($urandom(), $urandom(), nr, 1'b0, 8'h42);
      cyc = 0;
      while (txnCount < base + nr + 2 && cyc < 2000) begin
         @(negedge clk_i);
         cyc++;
      end
      checkOutput("clear_setup_timeout", 32'(cyc < 2000), 1);
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      checkOutput("clear_req", 32'(req_o), 0);
      checkOutput("clear_busy", 32'(busy_o), 0);
      checkOutput("clear_ready", 32'(job_ready_o), 1);
      checkOutput("clear_add", add_o, 0);
      expQ.delete();
      acqPlan.delete();
      base = txnCount;
      repeat (12) @(negedge clk_i);
      checkOutput("clear_no_bus", txnCount, base);
      checkOutput("clear_no_done", doneCount, expectedDones);

      maxGntDelay = 2;
      applyStimulus($urandom(), $urandom(), 1, 1'b0, 8'h5A);
      waitJob(8'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
